// File: rtl/pipe_ctrl_pkg.sv
// Pipeline run-control shared definitions.
// State encodings and drain default, shared with the debug unit.
package pipe_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } pc_state_e;

  localparam int DRAIN_CYCLES_DEF = 4;
  localparam int DRAIN_W          = 4;

  function automatic logic is_busy(input pc_state_e s);
    return (s == S_RUN) || (s == S_STEP) || (s == S_DRAIN);
  endfunction

  function automatic logic is_exec(input pc_state_e s);
    return (s == S_RUN) || (s == S_STEP);
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline run/step/halt controller with drain and cycle counter.
// Cycle counter present only when PIPE_CTRL_CYCLE_CNT_EN is defined.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 32
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_run,
  input  logic             i_step,
  input  logic             i_halt_fetched,
  input  logic             i_hazard_stall,
  output logic             o_pc_write,
  output logic             o_if_id_write,
  output logic             o_bubble,
  output logic             o_pipe_en,
  output logic             o_busy,
  output logic             o_done,
  output logic [CNT_W-1:0] o_cycle_cnt
);

  pc_state_e          r_state;
  pc_state_e          w_next;
  logic [DRAIN_W-1:0] r_drain;
  logic               w_drain_ld;

  // State register
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and zero-latency enable decode
  always_comb begin
    w_next        = r_state;
    w_drain_ld    = 1'b0;
    o_pc_write    = 1'b0;
    o_if_id_write = 1'b0;
    o_bubble      = 1'b0;
    o_pipe_en     = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (i_run) begin
          w_next = S_RUN;
        end else if (i_step) begin
          w_next = S_STEP;
        end
      end
      S_RUN: begin
        o_pipe_en     = 1'b1;
        o_pc_write    = ~i_hazard_stall;
        o_if_id_write = ~i_hazard_stall;
        o_bubble      = i_hazard_stall;
        // a stalled HALT is not really fetched yet
        if (i_halt_fetched && !i_hazard_stall) begin
          w_next     = S_DRAIN;
          w_drain_ld = 1'b1;
        end
      end
      S_STEP: begin
        o_pipe_en     = 1'b1;
        o_pc_write    = ~i_hazard_stall;
        o_if_id_write = ~i_hazard_stall;
        o_bubble      = i_hazard_stall;
        if (i_halt_fetched) begin
          w_next     = S_DRAIN;
          w_drain_ld = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_DRAIN: begin
        o_pipe_en = 1'b1;
        if (r_drain <= DRAIN_W'(1)) begin
          w_next = S_DONE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Status flags
  assign o_busy = is_busy(r_state);
  assign o_done = (r_state == S_DONE);

  // Drain counter: loaded on HALT, counts down through DRAIN
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_drain <= '0;
    end else if (w_drain_ld) begin
      r_drain <= DRAIN_W'(DRAIN_CYCLES);
    end else if (r_state == S_DRAIN && r_drain != '0) begin
      r_drain <= r_drain - DRAIN_W'(1);
    end
  end

`ifdef PIPE_CTRL_CYCLE_CNT_EN
  logic [CNT_W-1:0] r_cnt;
  logic             w_restart;

  assign w_restart = (r_state == S_DONE) && (i_run || i_step);

  // Saturating count of enabled cycles, cleared on restart from DONE
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (w_restart) begin
      r_cnt <= '0;
    end else if (o_pipe_en && r_cnt != '1) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cycle_cnt = r_cnt;
`else
  assign o_cycle_cnt = '0;
`endif

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DRAIN_CYCLES, 4, cycles the pipeline runs after HALT is fetched so in-flight instructions reach WB; legal range 1..15.
REQ-002 Parameter CNT_W, 32, width of the cycle counter.
REQ-003 i_clock  in  1  single clock; all state updates on its rising edge.
REQ-004 i_reset_n  in  1  reset, asynchronous, active-low.
REQ-005 i_run  in  1  one-cycle pulse: start continuous execution.
REQ-006 i_step  in  1  one-cycle pulse: advance the pipeline exactly one cycle.
REQ-007 i_halt_fetched  in  1  HALT opcode present in IF this cycle.
REQ-008 i_hazard_stall  in  1  load-use stall request from hazard detection, active-high.
REQ-009 o_pc_write  out  1  PC register enable.
REQ-010 o_if_id_write  out  1  IF/ID register enable.
REQ-011 o_bubble  out  1  force zero control bits into ID/EX.
REQ-012 o_pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB registers and register-file/memory writes.
REQ-013 o_busy  out  1  state is RUN, STEP or DRAIN.
REQ-014 o_done  out  1  state is DONE.
REQ-015 o_cycle_cnt  out  CNT_W  count of cycles with o_pipe_en=1 since last start.

Function
REQ-016 States: IDLE, RUN, STEP, DRAIN, DONE; registered, encoded 3 bits.
REQ-017 IDLE: all enables 0; i_run -> RUN; else i_step -> STEP; i_run has priority when both asserted.
REQ-018 RUN: o_pipe_en=1 every cycle; i_halt_fetched -> DRAIN with drain counter loaded to DRAIN_CYCLES.
REQ-019 STEP: o_pipe_en=1 for exactly that one cycle; next state IDLE, or DRAIN if i_halt_fetched that cycle.
REQ-020 DRAIN: o_pipe_en=1, o_pc_write=0, o_if_id_write=0; counter decrements each cycle; at count 1 -> DONE.
REQ-021 DONE: all enables 0; i_run or i_step -> IDLE-equivalent restart: counter clears, HALT-fetch memory clears, next state RUN/STEP per REQ-017 priority.
REQ-022 In RUN and STEP, o_pc_write = o_if_id_write = ~i_hazard_stall, o_bubble = i_hazard_stall; o_pipe_en unaffected by stall.
REQ-023 o_bubble=0 in every state other than RUN/STEP; stall ignored in DRAIN.
REQ-024 i_halt_fetched together with i_hazard_stall in RUN: stall wins that cycle (PC held, no DRAIN); DRAIN entered only on a non-stalled HALT cycle.
REQ-025 i_run/i_step while in RUN, STEP or DRAIN: ignored, no queuing.
REQ-026 All outputs combinational from registered state and current inputs; zero-latency enable response.
REQ-027 Cycle counter increments on every cycle with o_pipe_en=1; saturates at all-ones, no wrap.

Reset
REQ-028 i_reset_n=0 forces, asynchronously, state IDLE, drain counter 0, cycle counter 0; all outputs 0.
REQ-029 Reset mid-RUN or mid-DRAIN abandons operation; no enable pulse on deassertion; first action is next i_run/i_step.

Configuration
REQ-030 Macro PIPE_CTRL_CYCLE_CNT_EN defined: cycle counter implemented per REQ-027.
REQ-031 Macro undefined: no counter flops; o_cycle_cnt tied to 0; all other behaviour identical.

Structure
REQ-032 Shared package/header holds state encodings (IDLE=0, RUN=1, STEP=2, DRAIN=3, DONE=4) and DRAIN_CYCLES default, reused by the debug unit.
REQ-033 Single flat module; no sub-modules; drain counter and cycle counter inline.

Verification
REQ-034 Reset, i_step pulse -> o_pipe_en/o_pc_write high exactly 1 cycle, back to IDLE, o_cycle_cnt=1.
REQ-035 i_run, 10 cycles, i_halt_fetched at cycle 10 -> 4 drain cycles with o_pc_write=0, o_pipe_en=1, then o_done=1, o_cycle_cnt=14.
REQ-036 RUN with i_hazard_stall=1 for 1 cycle -> o_pc_write=0, o_if_id_write=0, o_bubble=1, o_pipe_en=1 that cycle only.
REQ-037 i_halt_fetched and i_hazard_stall same cycle, then HALT without stall next cycle -> DRAIN starts on second cycle.
REQ-038 i_reset_n low at drain count 2 -> all outputs 0 immediately, IDLE, o_cycle_cnt=0.
REQ-039 Macro undefined, run to DONE -> o_cycle_cnt stays 0, enable sequence identical to REQ-035.
